// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types, vector defaults and address helper for irq_requester
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    // Vector arithmetic is modulo 2^32; a wrapped address is intentional, not an error.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] id32);
        return base + id32 * stride;
    endfunction

endpackage

// File: rtl/irq_requester_if.sv
// rtl/irq_requester_if.sv - interrupt source/request bundle between accelerators, core and requester
interface irq_requester_if #(
    parameter int NUM_SRC = 4
);
    localparam int ID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] done;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wd;
    logic               int_ack;
    logic               eoi;
    logic               interrupt;
    logic [31:0]        int_addr;
    logic [ID_W-1:0]    int_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               in_service;

    // master: the requester raising the interrupt; slave: the core/accelerator side
    modport master (
        input  done, mask_we, mask_wd, int_ack, eoi,
        output interrupt, int_addr, int_id, pending, mask, in_service
    );

    modport slave (
        output done, mask_we, mask_wd, int_ack, eoi,
        input  interrupt, int_addr, int_id, pending, mask, in_service
    );

endinterface

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - combinational fixed-priority encoder, bit 0 highest priority
module prio_enc #(
    parameter  int NUM_SRC = 4,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    always_comb begin
        any    = |eligible;
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_requester.sv
// rtl/irq_requester.sv - pending capture, masking, fixed-priority arbitration and interrupt handshake FSM
module irq_requester
    import irq_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic           clk,
    input  logic           reset,
    irq_requester_if.master bus
);

    localparam int ID_W = $clog2(NUM_SRC);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] done_q, done_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic [31:0]        int_addr_q, int_addr_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] eligible;
    logic               any;
    logic [ID_W-1:0]    winner;

    assign eligible = pending_q & ~mask_q;

    prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .eligible (eligible),
        .any      (any),
        .winner   (winner)
    );

    always_comb begin
        state_d    = state_q;
        int_id_d   = int_id_q;
        int_addr_d = int_addr_q;
        clr        = '0;
        rise       = bus.done & ~done_q;

        case (state_q)
            IDLE: begin
                if (any) begin
                    int_id_d   = winner;
                    int_addr_d = vec_addr(VEC_BASE, VEC_STRIDE, 32'(winner));
                    state_d    = REQ;
                end
            end
            REQ: begin
                // The granted request is frozen here; masks and new edges only affect the next grant.
                if (bus.int_ack) begin
                    clr     = NUM_SRC'(1) << int_id_q;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q & ~clr) | rise;
        mask_d    = bus.mask_we ? bus.mask_wd : mask_q;
        done_d    = bus.done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            done_q     <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            int_id_q   <= '0;
            int_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_id_q   <= int_id_d;
            int_addr_q <= int_addr_d;
        end
    end

    assign bus.interrupt  = (state_q == REQ);
    assign bus.in_service = (state_q == SERVICE);
    assign bus.int_id     = int_id_q;
    assign bus.int_addr   = int_addr_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule

// File: tb/tb_irq_requester.sv
// tb/tb_irq_requester.sv - randomized and directed self-checking bench for irq_requester
module tb_irq_requester;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    irq_requester_if #(.NUM_SRC(N)) bus ();
    irq_requester_if #(.NUM_SRC(N)) bus2 ();

    irq_requester #(.NUM_SRC(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    irq_requester #(.NUM_SRC(N), .VEC_BASE(32'hFFFF_FFF0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.done    = bus.done;
    assign bus2.mask_we = bus.mask_we;
    assign bus2.mask_wd = bus.mask_wd;
    assign bus2.int_ack = bus.int_ack;
    assign bus2.eoi     = bus.eoi;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference: phase 0 = no request, 1 = request outstanding, 2 = handler running
    logic [N-1:0] m_pend, m_mask, m_prev_done, m_rise, m_next;
    int           m_phase, m_id, m_win;
    logic [31:0]  m_addr, m_addr2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_prev_done = '0;
            m_phase = 0; m_id = 0; m_addr = '0; m_addr2 = '0;
        end else begin
            m_rise = bus.done & ~m_prev_done;
            m_next = m_pend | m_rise;
            if (m_phase == 0) begin
                m_win = -1;
                for (int i = 0; i < N; i++)
                    if (m_win < 0 && m_pend[i] && !m_mask[i]) m_win = i;
                if (m_win >= 0) begin
                    m_phase = 1;
                    m_id    = m_win;
                    m_addr  = 32'h0000_0100 + 32'(m_win) * 32'h10;
                    m_addr2 = 32'hFFFF_FFF0 + 32'(m_win) * 32'h10;
                end
            end else if (m_phase == 1) begin
                if (bus.int_ack) begin
                    m_phase = 2;
                    if (!m_rise[m_id]) m_next[m_id] = 1'b0;
                end
            end else if (bus.eoi) begin
                m_phase = 0;
            end
            m_pend = m_next;
            if (bus.mask_we) m_mask = bus.mask_wd;
            m_prev_done = bus.done;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_interrupt",  32'(bus.interrupt),  32'(m_phase == 1));
            check("m_in_service", 32'(bus.in_service), 32'(m_phase == 2));
            check("m_pending",    32'(bus.pending),    32'(m_pend));
            check("m_mask",       32'(bus.mask),       32'(m_mask));
            check("m_int_id",     32'(bus.int_id),     32'(m_id));
            check("m_int_addr",   bus.int_addr,        m_addr);
            check("m_int_addr2",  bus2.int_addr,       m_addr2);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int src);
        bus.done[src] = 1'b1;
        tick();
        bus.done[src] = 1'b0;
    endtask

    task automatic do_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!bus.interrupt && n < budget) begin
            tick();
            n++;
        end
        check("wait_irq_timeout", 32'(bus.interrupt), 32'd1);
    endtask

    initial begin
        reset       = 1'b0;
        bus.done    = 4'b0101;
        bus.mask_we = 1'b0;
        bus.mask_wd = '0;
        bus.int_ack = 1'b0;
        bus.eoi     = 1'b0;
        chk_en      = 1'b1;

        // 1: reset with done held
        repeat (3) tick();
        check("rst_interrupt", 32'(bus.interrupt), 32'd0);
        check("rst_pending",   32'(bus.pending),   32'd0);
        check("rst_addr",      bus.int_addr,       32'd0);
        bus.done = '0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("idle_no_req", 32'(bus.interrupt), 32'd0);

        // 2: single source full handshake
        pulse(2);
        check("t2_pending", 32'(bus.pending),   32'h4);
        check("t2_irq_lo",  32'(bus.interrupt), 32'd0);
        tick();
        check("t2_irq",  32'(bus.interrupt), 32'd1);
        check("t2_id",   32'(bus.int_id),    32'd2);
        check("t2_addr", bus.int_addr,       32'h120);
        repeat (2) tick();
        do_ack();
        check("t2_ack_irq",  32'(bus.interrupt),  32'd0);
        check("t2_ack_pend", 32'(bus.pending),    32'd0);
        check("t2_svc",      32'(bus.in_service), 32'd1);
        repeat (2) tick();
        do_eoi();
        check("t2_eoi", 32'(bus.in_service), 32'd0);

        // 3: simultaneous sources, priority order and wrapped vector
        bus.done = 4'b1010;
        tick();
        bus.done = '0;
        tick();
        check("t3_id1",    32'(bus.int_id), 32'd1);
        check("t3_addr1",  bus.int_addr,    32'h110);
        check("t3_wrap1",  bus2.int_addr,   32'h0);
        do_ack();
        do_eoi();
        wait_irq(10);
        check("t3_id3",   32'(bus.int_id), 32'd3);
        check("t3_addr3", bus.int_addr,    32'h130);
        check("t3_wrap3", bus2.int_addr,   32'h20);
        do_ack();
        do_eoi();
        tick();

        // 4: masked source latches but does not request until unmasked
        bus.mask_we = 1'b1; bus.mask_wd = 4'b0001;
        tick();
        bus.mask_we = 1'b0;
        pulse(0);
        repeat (3) tick();
        check("t4_pend", 32'(bus.pending),   32'h1);
        check("t4_mask", 32'(bus.interrupt), 32'd0);
        bus.mask_we = 1'b1; bus.mask_wd = '0;
        tick();
        bus.mask_we = 1'b0;
        check("t4_lat1", 32'(bus.interrupt), 32'd0);
        tick();
        check("t4_lat2", 32'(bus.interrupt), 32'd1);
        check("t4_id",   32'(bus.int_id),    32'd0);
        do_ack();
        do_eoi();
        tick();

        // 5: edges and stray acks during SERVICE
        pulse(2);
        wait_irq(10);
        do_ack();
        pulse(0);
        for (int i = 0; i < 4; i++) begin
            bus.int_ack = ~bus.int_ack;
            tick();
            check("t5_no_req", 32'(bus.interrupt),  32'd0);
            check("t5_svc",    32'(bus.in_service), 32'd1);
        end
        bus.int_ack = 1'b0;
        do_eoi();
        check("t5_eoi_lat", 32'(bus.interrupt), 32'd0);
        tick();
        check("t5_irq", 32'(bus.interrupt), 32'd1);
        check("t5_id",  32'(bus.int_id),    32'd0);
        do_ack();
        do_eoi();
        tick();

        // 6: asynchronous reset while requesting
        pulse(1);
        wait_irq(10);
        pulse(3);
        #2 reset = 1'b0;
        #1;
        check("t6_irq",  32'(bus.interrupt),  32'd0);
        check("t6_pend", 32'(bus.pending),    32'd0);
        check("t6_svc",  32'(bus.in_service), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            bus.done    = bus.done ^ N'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.mask_we = ($urandom_range(0, 15) == 0);
            bus.mask_wd = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.int_ack = ($urandom_range(0, 2) == 0);
            bus.eoi     = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.done = '0; bus.mask_we = 1'b0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
        repeat (4) tick();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
